// File: rtl/bytewise_ram_pkg.sv
// rtl/bytewise_ram_pkg.sv - shared definitions for the byte-lane RAM
//
// Purpose: controller state encoding, lane width and lane-count helper shared by
//          bytewise_ram and bytewise_ram_array.
// Ports:   none (package).
package bytewise_ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int BYTE = 8;

    // Number of byte lanes in a word of w bits.
    function automatic int lanes(input int w);
        return w / BYTE;
    endfunction

endpackage

// File: rtl/bytewise_ram_array.sv
// rtl/bytewise_ram_array.sv - lane-writable storage array with asynchronous read
//
// Purpose: holds 1<<ADDR_WIDTH words of NUM_LANES lanes, each LANE_W bits wide.
//          Each lane has its own write enable; the read port is combinational and
//          the top registers it.
// Ports:
//   clk   in   rising-edge clock
//   we    in   NUM_LANES   per-lane write enables
//   addr  in   ADDR_WIDTH  word address shared by read and write
//   d     in   NUM_LANES*LANE_W write data
//   q     out  NUM_LANES*LANE_W read data at addr
module bytewise_ram_array #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                          clk,
    input  logic [NUM_LANES-1:0]          we,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [NUM_LANES*LANE_W-1:0]   d,
    output logic [NUM_LANES*LANE_W-1:0]   q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [NUM_LANES*LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we[i]) begin
                mem[addr][i*LANE_W +: LANE_W] <= d[i*LANE_W +: LANE_W];
            end
        end
    end

    assign q = mem[addr];

endmodule

// File: rtl/bytewise_ram.sv
// rtl/bytewise_ram.sv - byte-lane-writable RAM with handshake, registered read and clear engine
//
// Purpose: word store for the multicycle datapath. After reset (or a clear pulse)
//          a clear engine writes CLEAR_VALUE to one word per cycle; afterwards one
//          read or lane-masked write is accepted per cycle and acknowledged the
//          following cycle.
// Option:  define RAM_PARITY_EN to store an even-parity bit per byte lane and
//          flag mismatches on reads through parityErr; otherwise parityErr is 0.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; restarts the clear engine
//   clear      in   pulse: restart the clear engine from word 0
//   req        in   request valid
//   write      in   1 = write, 0 = read
//   addr       in   ADDR_WIDTH word address
//   byteEn     in   WIDTH/8 write lane enables
//   inData     in   WIDTH write data
//   ready      out  request can be accepted this cycle
//   ack        out  pulse the cycle after an accepted request
//   outData    out  WIDTH read data, held until the next read ack
//   busy       out  clear engine running
//   parityErr  out  read found a lane parity mismatch (valid with ack)
module bytewise_ram
    import bytewise_ram_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               ADDR_WIDTH  = 10,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  req,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH/8-1:0]    byteEn,
    input  logic [WIDTH-1:0]      inData,
    output logic                  ready,
    output logic                  ack,
    output logic [WIDTH-1:0]      outData,
    output logic                  busy,
    output logic                  parityErr
);

    localparam int NUM_LANES = lanes(WIDTH);
`ifdef RAM_PARITY_EN
    localparam int LANE_W = BYTE + 1;
`else
    localparam int LANE_W = BYTE;
`endif

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     clr_addr_q, clr_addr_d;
    logic                      ack_q, ack_d;
    logic [WIDTH-1:0]          out_data_q, out_data_d;

    logic                      accept;
    logic [NUM_LANES-1:0]      arr_we;
    logic [ADDR_WIDTH-1:0]     arr_addr;
    logic [WIDTH-1:0]          wr_src;
    logic [NUM_LANES*LANE_W-1:0] arr_d;
    logic [NUM_LANES*LANE_W-1:0] arr_q;
    logic [WIDTH-1:0]          rd_data;

`ifdef RAM_PARITY_EN
    logic                      parity_err_q, parity_err_d;
    logic                      rd_perr;
`endif

    // Moore outputs: only the state decides availability.
    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q == ST_CLEAR);
    // A clear pulse takes priority and drops any request presented with it.
    assign accept = req & ready & ~clear;

    // Write data path: the clear engine and the requester share one write port.
    assign wr_src = (state_q == ST_CLEAR) ? CLEAR_VALUE : inData;

    always_comb begin
        arr_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            arr_d[i*LANE_W +: BYTE] = wr_src[i*BYTE +: BYTE];
`ifdef RAM_PARITY_EN
            arr_d[i*LANE_W + BYTE] = ^wr_src[i*BYTE +: BYTE];
`endif
        end
    end

    // Read data path: strip (and check) per-lane parity.
    always_comb begin
        rd_data = '0;
`ifdef RAM_PARITY_EN
        rd_perr = 1'b0;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
            rd_data[i*BYTE +: BYTE] = arr_q[i*LANE_W +: BYTE];
`ifdef RAM_PARITY_EN
            rd_perr = rd_perr
                    | ((^arr_q[i*LANE_W +: BYTE]) ^ arr_q[i*LANE_W + BYTE]);
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ack_d      = 1'b0;
        out_data_d = out_data_q;
        arr_we     = '0;
        arr_addr   = addr;
`ifdef RAM_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_CLEAR: begin
                if (clear) begin
                    clr_addr_d = '0;
                end else begin
                    arr_we     = '1;
                    arr_addr   = clr_addr_q;
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                    // Last word is written on this edge, so leave now.
                    if (clr_addr_q == '1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (accept) begin
                    ack_d = 1'b1;
                    if (write) begin
                        arr_we = byteEn;
                    end else begin
                        out_data_d = rd_data;
`ifdef RAM_PARITY_EN
                        parity_err_d = rd_perr;
`endif
                    end
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            ack_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ack_q      <= ack_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parityErr = parity_err_q;
`else
    assign parityErr = 1'b0;
`endif

    assign ack     = ack_q;
    assign outData = out_data_q;

    // Writes during reset are harmless: the clear engine rewrites every word.
    bytewise_ram_array #(
        .NUM_LANES  (NUM_LANES),
        .LANE_W     (LANE_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (arr_addr),
        .d    (arr_d),
        .q    (arr_q)
    );

endmodule
